wb_grf_commit: RTL and testbench
================================

// Module: wb_grf_commit
// PURPOSE
//  Writeback stage fed by the M/W pipeline register. Selects the W-stage
//  write-back value and commits it to the 32x32 general register file (GRF).
//  Provides two D-stage read ports with same-cycle write bypass. Pushes every
//  commit into a small trace FIFO, drained over a valid/ready port by the
//  commit monitor.
// PARAMETERS
//  TRACE_DEPTH  4  trace FIFO entries; power of two, >=2
//  ZERO_TRACE   0  1: writes aimed at $0 are also traced (GRF stays unchanged)
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   asynchronous, active-low (0 = reset)
//  W_pc           in   32  PC of the W-stage instruction
//  W_writeReg     in   5   destination register
//  W_regWrite     in   1   W-stage instruction writes the GRF
//  W_wdSel        in   3   0 alu, 1 mem, 2 pc+8, 3 md, 4 cp0, 5-7 zero
//  W_aluResult    in   32  ALU result
//  W_memData      in   32  load data (already extended)
//  W_valueMDwrite in   32  HI/LO read value
//  W_cp0Out       in   32  CP0 read value
//  rs_addr        in   5   read port A address
//  rt_addr        in   5   read port B address
//  rs_data        out  32  read port A data (combinational)
//  rt_data        out  32  read port B data (combinational)
//  W_wd           out  32  selected write-back value (combinational)
//  trace_valid    out  1   FIFO head is valid
//  trace_ready    in   1   consumer accepts the head
//  trace_pc       out  32  head PC
//  trace_reg      out  5   head destination register
//  trace_data     out  32  head data
//  trace_overflow out  1   sticky: a trace entry was dropped
//  retire_count   out  32  number of GRF commits since reset
// BEHAVIOUR
//  - W_wd = mux by W_wdSel. pc+8 = W_pc + 32'd8, mod 2^32. Sel 5-7 gives 0.
//  - commit = W_regWrite & (W_writeReg != 0).
//  - On a posedge with commit, write W_wd to grf[W_writeReg]. $0 is always
//    read as 0 and is never stored.
//  - Read X (X = rs/rt):
//    - X_addr==0 gives 0.
//    - Else, commit & X_addr==W_writeReg gives W_wd (bypass).
//    - Else, grf[X_addr].
//  - Trace event: W_regWrite & (W_writeReg!=0 | ZERO_TRACE).
//    Entry = {W_pc, W_writeReg, W_wd}.
//  - Pop occurs on a posedge when trace_valid & trace_ready.
//  - Push occurs on an event when the FIFO is not full, or when it is full
//    and a pop happens in the same cycle.
//  - An event while full with no pop drops the entry and sets trace_overflow.
//    trace_overflow stays 1 until reset.
//  - A pushed entry is visible at the head one cycle later; there is no
//    fall-through. Head order is FIFO.
//  - Pointers wrap modulo TRACE_DEPTH. Occupancy count is log2(DEPTH)+1 bits.
//  - trace_* data outputs are don't-care while trace_valid=0 (driven from the
//    array, not forced).
//  - retire_count increments by 1 per commit and wraps 0xFFFFFFFF -> 0.
//  - Reset (reset=0, asynchronous, also mid-operation) immediately does all
//    of the following, with no writes while reset=0:
//    - all GRF entries 0
//    - FIFO empty (trace_valid=0)
//    - trace_overflow=0
//    - retire_count=0
//  - After reset, rs_data/rt_data/W_wd are 0 while the upstream register
//    outputs are held at 0.
//  - Latency: GRF write 1 cycle (bypass makes it visible in the same cycle).
//    Trace entry 1 cycle.
// TESTING
//  1. After reset, write $5 (sel0, alu=0x1234) -> rs_addr=5 reads 0x1234 in
//     the same cycle, and again next cycle from the GRF; retire_count=1.
//  2. regWrite=1, reg=0, alu=0xFFFF -> rs_addr=0 reads 0, retire_count
//     unchanged, no trace event (ZERO_TRACE=0).
//  3. Drive each sel with W_pc=0x3000, mem=0xA, md=0xB, cp0=0xC ->
//     W_wd = alu / 0xA / 0x3008 / 0xB / 0xC, and 0 for sel 5-7.
//  4. trace_ready=0, 5 commits -> 4 entries held, trace_overflow=1.
//     Raise ready -> pops in order with PCs 1..4; 5th is absent.
//  5. FIFO full, ready=1, and an event in the same cycle -> pop and push
//     both occur, occupancy stays 4, no overflow.
//  6. Assert reset mid-burst (FIFO 2 deep, GRF nonzero) -> trace_valid=0,
//     reads 0, and retire_count=0 before the next clock edge.

Source files
------------

// File: rtl/wb_grf_commit.sv
// Writeback stage: selects the W-stage result, commits it to the 32x32 GRF,
// serves two bypassed D-stage read ports and records commits in a trace FIFO.
module wb_grf_commit #(
  parameter int TRACE_DEPTH = 4,
  parameter bit ZERO_TRACE  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_pc,
  input  logic [4:0]  W_writeReg,
  input  logic        W_regWrite,
  input  logic [2:0]  W_wdSel,
  input  logic [31:0] W_aluResult,
  input  logic [31:0] W_memData,
  input  logic [31:0] W_valueMDwrite,
  input  logic [31:0] W_cp0Out,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] W_wd,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_reg,
  output logic [31:0] trace_data,
  output logic        trace_overflow,
  output logic [31:0] retire_count
);

  localparam int AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TRACE_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1'b1);

  logic [31:0][31:0]            grf_r;
  logic [TRACE_DEPTH-1:0][31:0] pc_mem_r;
  logic [TRACE_DEPTH-1:0][4:0]  reg_mem_r;
  logic [TRACE_DEPTH-1:0][31:0] data_mem_r;
  logic [AW-1:0]                wr_ptr_r;
  logic [AW-1:0]                rd_ptr_r;
  logic [AW:0]                  count_r;
  logic                         overflow_r;
  logic [31:0]                  retire_r;

  logic [31:0] wd_s;
  logic        commit_s;
  logic        event_s;
  logic        full_s;
  logic        pop_s;
  logic        push_s;
  logic        drop_s;

  // Write-back value selection; unused selector codes yield zero.
  always_comb begin
    wd_s = 32'd0;
    case (W_wdSel)
      3'd0:    wd_s = W_aluResult;
      3'd1:    wd_s = W_memData;
      3'd2:    wd_s = W_pc + 32'd8;
      3'd3:    wd_s = W_valueMDwrite;
      3'd4:    wd_s = W_cp0Out;
      default: wd_s = 32'd0;
    endcase
  end

  assign commit_s = W_regWrite & (W_writeReg != 5'd0);
  assign event_s  = W_regWrite & ((W_writeReg != 5'd0) | ZERO_TRACE);
  assign full_s   = (count_r == DEPTH_C);
  assign pop_s    = (count_r != {(AW+1){1'b0}}) & trace_ready;
  assign push_s   = event_s & (~full_s | pop_s);
  assign drop_s   = event_s & full_s & ~pop_s;

  // Read ports: $0 is hardwired zero, a same-cycle commit bypasses the array.
  always_comb begin
    rs_data = 32'd0;
    rt_data = 32'd0;
    if (rs_addr == 5'd0) begin
      rs_data = 32'd0;
    end else if (commit_s && (rs_addr == W_writeReg)) begin
      rs_data = wd_s;
    end else begin
      rs_data = grf_r[rs_addr];
    end
    if (rt_addr == 5'd0) begin
      rt_data = 32'd0;
    end else if (commit_s && (rt_addr == W_writeReg)) begin
      rt_data = wd_s;
    end else begin
      rt_data = grf_r[rt_addr];
    end
  end

  // GRF commit; $0 is never stored because commit excludes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_r <= '0;
    end else if (commit_s) begin
      grf_r[W_writeReg] <= wd_s;
    end
  end

  // Trace storage: payload only, validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (push_s && reset) begin
      pc_mem_r[wr_ptr_r]   <= W_pc;
      reg_mem_r[wr_ptr_r]  <= W_writeReg;
      data_mem_r[wr_ptr_r] <= wd_s;
    end
  end

  // Trace pointers, occupancy, sticky overflow and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
      retire_r   <= 32'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (drop_s)   overflow_r <= 1'b1;
      if (commit_s) retire_r   <= retire_r + 32'd1;
    end
  end

  assign W_wd           = wd_s;
  assign trace_valid    = (count_r != {(AW+1){1'b0}});
  assign trace_pc       = pc_mem_r[rd_ptr_r];
  assign trace_reg      = reg_mem_r[rd_ptr_r];
  assign trace_data     = data_mem_r[rd_ptr_r];
  assign trace_overflow = overflow_r;
  assign retire_count   = retire_r;

endmodule

// File: tb/tb_wb_grf_commit.sv
// Bench for wb_grf_commit: directed scenarios plus random traffic checked
// against a queue/array reference model.
`timescale 1ns/1ps
module tb_wb_grf_commit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_pc, W_aluResult, W_memData, W_valueMDwrite, W_cp0Out;
  logic [4:0]  W_writeReg, rs_addr, rt_addr;
  logic        W_regWrite, trace_ready;
  logic [2:0]  W_wdSel;
  logic [31:0] rs_data, rt_data, W_wd, trace_pc, trace_data, retire_count;
  logic [4:0]  trace_reg;
  logic        trace_valid, trace_overflow;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic [31:0] m_grf [32];
  ent_t        m_q [$];
  bit          m_ovf;
  logic [31:0] m_ret;

  wb_grf_commit #(.TRACE_DEPTH(DEPTH), .ZERO_TRACE(1'b0)) dut (
    .clk(clk), .reset(reset), .W_pc(W_pc), .W_writeReg(W_writeReg),
    .W_regWrite(W_regWrite), .W_wdSel(W_wdSel), .W_aluResult(W_aluResult),
    .W_memData(W_memData), .W_valueMDwrite(W_valueMDwrite), .W_cp0Out(W_cp0Out),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .W_wd(W_wd), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_data(trace_data),
    .trace_overflow(trace_overflow), .retire_count(retire_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_wd();
    case (W_wdSel)
      3'd0:    return W_aluResult;
      3'd1:    return W_memData;
      3'd2:    return W_pc + 32'd8;
      3'd3:    return W_valueMDwrite;
      3'd4:    return W_cp0Out;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_commit();
    return W_regWrite && (W_writeReg != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_commit() && a == W_writeReg) return m_wd();
    return m_grf[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
    m_q.delete();
    m_ovf = 1'b0;
    m_ret = 32'd0;
  endtask

  task automatic drive_idle();
    W_pc = 32'd0; W_writeReg = 5'd0; W_regWrite = 1'b0; W_wdSel = 3'd0;
    W_aluResult = 32'd0; W_memData = 32'd0; W_valueMDwrite = 32'd0; W_cp0Out = 32'd0;
    rs_addr = 5'd0; rt_addr = 5'd0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".wd"}, W_wd, m_wd());
    chk({ph, ".rs"}, rs_data, m_read(rs_addr));
    chk({ph, ".rt"}, rt_data, m_read(rt_addr));
    chk({ph, ".valid"}, 32'(trace_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk({ph, ".tpc"}, trace_pc, m_q[0].pc);
      chk({ph, ".treg"}, 32'(trace_reg), 32'(m_q[0].r));
      chk({ph, ".tdata"}, trace_data, m_q[0].d);
    end
    chk({ph, ".ovf"}, 32'(trace_overflow), 32'(m_ovf));
    chk({ph, ".retire"}, retire_count, m_ret);
  endtask

  // One clock: check combinational view at negedge, then advance the model
  // at the posedge using the inputs that the DUT sampled.
  task automatic tick(input string ph);
    bit ev;
    @(negedge clk);
    check_all(ph);
    @(posedge clk);
    ev = W_regWrite && (W_writeReg != 5'd0);
    if (m_q.size() > 0 && trace_ready) void'(m_q.pop_front());
    if (ev) begin
      if (m_q.size() < DEPTH) m_q.push_back('{W_pc, W_writeReg, m_wd()});
      else m_ovf = 1'b1;
    end
    if (m_commit()) begin
      m_grf[W_writeReg] = m_wd();
      m_ret = m_ret + 32'd1;
    end
    #1;
  endtask

  task automatic set_write(input logic [31:0] pc, input logic [4:0] r, input logic [31:0] alu);
    W_regWrite = 1'b1; W_writeReg = r; W_wdSel = 3'd0; W_aluResult = alu; W_pc = pc;
  endtask

  initial begin
    reset = 1'b0;
    trace_ready = 1'b1;
    drive_idle();
    m_clear();
    #3;
    chk("rst.valid", 32'(trace_valid), 32'd0);
    chk("rst.retire", retire_count, 32'd0);
    chk("rst.ovf", 32'(trace_overflow), 32'd0);
    chk("rst.wd", W_wd, 32'd0);
    chk("rst.rs", rs_data, 32'd0);
    #9 reset = 1'b1;
    @(posedge clk); #1;

    // 1: write $5 with bypass then from the array.
    set_write(32'h100, 5'd5, 32'h1234); rs_addr = 5'd5; rt_addr = 5'd5;
    #1 chk("t1.bypass", rs_data, 32'h1234);
    tick("t1a");
    W_regWrite = 1'b0;
    #1 chk("t1.stored", rs_data, 32'h1234);
    chk("t1.retire", retire_count, 32'd1);
    tick("t1b");

    // 2: write to $0 is ignored and not traced.
    set_write(32'h104, 5'd0, 32'hFFFF); rs_addr = 5'd0;
    tick("t2a");
    W_regWrite = 1'b0;
    #1 chk("t2.rs0", rs_data, 32'd0);
    chk("t2.retire", retire_count, 32'd1);
    chk("t2.notrace", 32'(trace_valid), 32'd0);
    tick("t2b");

    // 3: every selector value.
    W_pc = 32'h3000; W_memData = 32'hA; W_valueMDwrite = 32'hB; W_cp0Out = 32'hC;
    W_aluResult = 32'h55;
    for (int s = 0; s < 8; s++) begin
      W_wdSel = 3'(s);
      #1 chk($sformatf("t3.sel%0d", s), W_wd,
             (s == 0) ? 32'h55 : (s == 1) ? 32'hA : (s == 2) ? 32'h3008 :
             (s == 3) ? 32'hB : (s == 4) ? 32'hC : 32'd0);
    end
    tick("t3");

    // 4: five commits with consumer stalled, then drain.
    trace_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_write(32'(i), 5'(i + 8), 32'(i * 16));
      tick("t4fill");
    end
    W_regWrite = 1'b0;
    #1 chk("t4.ovf", 32'(trace_overflow), 32'd1);
    trace_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1 chk($sformatf("t4.pop%0d", i), trace_pc, 32'(i));
      tick("t4drain");
    end
    chk("t4.empty", 32'(trace_valid), 32'd0);

    // 5: full FIFO, simultaneous pop and push.
    reset = 1'b0; #1 reset = 1'b1; m_clear();
    trace_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_write(32'h200 + 32'(i), 5'd7, 32'(i));
      tick("t5fill");
    end
    trace_ready = 1'b1;
    set_write(32'h2FF, 5'd8, 32'h77);
    tick("t5both");
    W_regWrite = 1'b0; trace_ready = 1'b0;
    #1 chk("t5.noovf", 32'(trace_overflow), 32'd0);
    chk("t5.head", trace_pc, 32'h202);
    chk("t5.count", 32'(m_q.size()), 32'd4);
    tick("t5hold");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      W_regWrite = ($urandom_range(0, 3) != 0);
      W_writeReg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      W_wdSel = 3'($urandom);
      W_pc = $urandom; W_aluResult = $urandom; W_memData = $urandom;
      W_valueMDwrite = $urandom; W_cp0Out = $urandom;
      rs_addr = ($urandom_range(0, 2) == 0) ? W_writeReg : 5'($urandom);
      rt_addr = ($urandom_range(0, 2) == 0) ? W_writeReg : 5'($urandom);
      trace_ready = 1'($urandom);
      tick("rnd");
    end

    // 6: asynchronous reset mid-burst.
    trace_ready = 1'b0;
    set_write(32'h400, 5'd3, 32'hDEAD); tick("t6a");
    set_write(32'h404, 5'd4, 32'hBEEF); tick("t6b");
    drive_idle(); rs_addr = 5'd3; rt_addr = 5'd4;
    #1 chk("t6.pre", rs_data, 32'hDEAD);
    #1 reset = 1'b0;
    #1;
    chk("t6.valid", 32'(trace_valid), 32'd0);
    chk("t6.rs", rs_data, 32'd0);
    chk("t6.rt", rt_data, 32'd0);
    chk("t6.retire", retire_count, 32'd0);
    chk("t6.ovf", 32'(trace_overflow), 32'd0);
    m_clear();
    #1 reset = 1'b1;
    tick("t6post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
